// File: rtl/nf_uart_receiver_mv.sv
// 8N1 UART receive core: two-flop synchroniser, start-bit verification and a
// three-sample majority vote per bit, with one-cycle valid / framing-error strobes.
module nf_uart_receiver_mv (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] comp,
  input  logic        rec_en,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_ferr,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, hist_q;
  logic [15:0] comp_l_q, comp_l_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ferr_q, rx_ferr_d;
  logic        busy_q, busy_d;

  logic        fall, bit_end, vote;
  logic [15:0] half;

  assign fall    = hist_q & ~sync2_q;
  assign half    = comp_l_q >> 1;
  assign bit_end = (cnt_q == comp_l_q - 16'd1);

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path infers a latch.
    state_d    = state_q;
    comp_l_d   = comp_l_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == half - 16'd1) s0_d = sync2_q;
      if (cnt_q == half)         s1_d = sync2_q;
      if (cnt_q == half + 16'd1) s2_d = sync2_q;
    end

    // The third sample can land on the very cycle the vote is consumed (stop bit,
    // or comp_l == 4), so the vote uses its next value.
    vote = (s0_q & s1_q) | (s0_q & s2_d) | (s1_q & s2_d);

    case (state_q)
      IDLE: begin
        if (rec_en && fall) begin
          comp_l_d = (comp < 16'd4) ? 16'd4 : comp;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d = '0;
          if (vote) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {vote, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        // Decided just past mid-bit so a following start edge is never missed.
        if (cnt_q == half + 16'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (vote) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rec_en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      hist_q     <= 1'b1;
      comp_l_q   <= 16'd4;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      comp_l_q   <= comp_l_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ferr  = rx_ferr_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_nf_uart_receiver_mv.sv
// Self-checking bench for nf_uart_receiver_mv: directed scenarios plus random
// frames, scored against a frame-level model of what each frame must produce.
module tb_nf_uart_receiver_mv;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] comp = 16'd434;
  logic        rec_en = 1'b0;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr, busy;

  nf_uart_receiver_mv dut (
    .clk(clk), .resetn(resetn), .comp(comp), .rec_en(rec_en), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         last_valid_cyc = -1;
  int         start_cyc = 0;
  exp_t       exp_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] model_data = 8'h00;
  logic       prev_pulse = 1'b0;
  exp_t       e;
  logic [7:0] hello [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    n_tests++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Compare process: every cycle, outputs against the frame-level model.
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      check("reset rx_data", 32'(rx_data), 32'h0);
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset rx_ferr", 32'(rx_ferr), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      model_data = 8'h00;
      exp_q.delete();
      prev_pulse = 1'b0;
    end else begin
      check("valid/ferr exclusive", 32'(rx_valid & rx_ferr), 32'h0);
      if (rx_valid || rx_ferr) begin
        check("pulse width one cycle", 32'(prev_pulse), 32'h0);
        check("busy low at pulse", 32'(busy), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected pulse {valid,ferr}", 32'({rx_valid, rx_ferr}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("pulse kind ferr", 32'(rx_ferr), 32'(e.ferr));
          if (!e.ferr) model_data = e.data;
        end
        if (rx_valid) begin
          n_valid++;
          last_valid_cyc = cyc;
          rx_log.push_back(rx_data);
        end else begin
          n_ferr++;
        end
      end
      check("rx_data", 32'(rx_data), 32'(model_data));
      prev_pulse = rx_valid | rx_ferr;
    end
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame with bits of max(c,4) clocks. spike_bit >= 0 puts a
  // 1-clock low pulse mid data bit; abort_kind 1 drops rec_en, 2 pulses resetn,
  // both at the middle of data bit abort_bit.
  task automatic send_frame(input logic [7:0] b, input int c, input bit stop_bit,
                            input int spike_bit, input int abort_bit, input int abort_kind,
                            input bit expect_pulse);
    int         ce;
    int         h;
    logic [9:0] frame;
    exp_t       x;
    ce    = (c < 4) ? 4 : c;
    h     = ce / 2;
    frame = {stop_bit, b, 1'b0};
    comp  = 16'(c);
    if (expect_pulse) begin
      x.ferr = !stop_bit;
      x.data = b;
      exp_q.push_back(x);
    end
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < ce; k++) begin
        @(negedge clk);
        if (i == 0 && k == 0) start_cyc = cyc;
        if (i == 2 && k == 0) comp = 16'($urandom);
        uart_rx = frame[i];
        if (i == spike_bit + 1 && k == h + 1) uart_rx = 1'b0;
        if (i == abort_bit + 1 && abort_kind == 1) begin
          if (k == h) rec_en = 1'b0;
          if (k == h + 1) check("busy low after rec_en drop", 32'(busy), 32'h0);
        end
        if (i == abort_bit + 1 && k == h && abort_kind == 2) begin
          resetn  = 1'b0;
          uart_rx = 1'b1;
          @(negedge clk);
          check("mid-frame reset rx_data", 32'(rx_data), 32'h0);
          check("mid-frame reset busy", 32'(busy), 32'h0);
          repeat (3) @(negedge clk);
          resetn = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic expect_drained(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    check("expected pulses delivered (left in queue)", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         v0;
    int         f0;
    int         c;
    int         gap;
    logic [7:0] b;
    bit         bad;

    repeat (4) @(negedge clk);
    check("reset rx_data literal", 32'(rx_data), 32'h00);
    check("reset busy literal", 32'(busy), 32'h0);
    resetn = 1'b1;
    rec_en = 1'b1;
    idle(20);

    // 'H' at the full-size divisor, latency pinned to the documented figure.
    send_frame(8'h48, 434, 1'b1, -1, -1, 0, 1'b1);
    expect_drained(100);
    check_near("H latency", last_valid_cyc - start_cyc, 4127, 1);
    check("H rx_data", 32'(rx_data), 32'h48);
    check("H valid count", 32'(n_valid), 32'd1);
    check("H ferr count", 32'(n_ferr), 32'd0);
    idle(10);

    // Back-to-back "Hello World!" with no idle gap.
    rx_log.delete();
    for (int i = 0; i < 12; i++) send_frame(hello[i], 32, 1'b1, -1, -1, 0, 1'b1);
    expect_drained(200);
    check("hello byte count", 32'(rx_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < rx_log.size(); i++)
      check($sformatf("hello byte %0d", i), 32'(rx_log[i]), 32'(hello[i]));
    idle(40);

    // Framing error keeps the last good byte; line held low never retriggers.
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h5A, 32, 1'b0, -1, -1, 0, 1'b1);
    repeat (300) @(negedge clk);
    check("ferr count", 32'(n_ferr - f0), 32'd1);
    check("ferr keeps rx_data", 32'(rx_data), 32'h21);
    check("no valid during ferr/low", 32'(n_valid - v0), 32'd0);
    idle(64);
    send_frame(8'h33, 32, 1'b1, -1, -1, 0, 1'b1);
    expect_drained(100);
    check("after ferr rx_data", 32'(rx_data), 32'h33);
    idle(40);

    // 3-clock glitch on idle line: false start, busy for about one bit.
    v0 = n_valid;
    f0 = n_ferr;
    comp = 16'd32;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (17) @(negedge clk);
    check("glitch busy high", 32'(busy), 32'h1);
    repeat (30) @(negedge clk);
    check("glitch busy low", 32'(busy), 32'h0);
    check("glitch no pulse", 32'((n_valid - v0) + (n_ferr - f0)), 32'd0);
    idle(20);

    // 1-clock spike mid bit 3 of 0xFF is outvoted.
    send_frame(8'hFF, 32, 1'b1, 3, -1, 0, 1'b1);
    expect_drained(100);
    check("spike rejected rx_data", 32'(rx_data), 32'hFF);
    idle(40);

    // rec_en dropped during bit 4, then a clean frame.
    v0 = n_valid;
    send_frame(8'hA5, 32, 1'b1, -1, 4, 1, 1'b0);
    idle(64);
    check("rec_en drop no pulse", 32'(n_valid - v0), 32'd0);
    rec_en = 1'b1;
    idle(20);
    send_frame(8'hA5, 32, 1'b1, -1, -1, 0, 1'b1);
    expect_drained(100);
    check("after rec_en rx_data", 32'(rx_data), 32'hA5);
    idle(40);

    // Reset mid bit 2, then a clean frame.
    send_frame(8'h3C, 32, 1'b1, -1, 2, 2, 1'b0);
    idle(40);
    v0 = n_valid;
    send_frame(8'h0F, 32, 1'b1, -1, -1, 0, 1'b1);
    expect_drained(100);
    check("after reset rx_data", 32'(rx_data), 32'h0F);
    check("after reset single valid", 32'(n_valid - v0), 32'd1);
    idle(40);

    // Divisors below 4 behave as 4.
    send_frame(8'hC3, 2, 1'b1, -1, -1, 0, 1'b1);
    idle(12);
    send_frame(8'h3A, 0, 1'b1, -1, -1, 0, 1'b1);
    idle(12);
    expect_drained(50);
    check("small comp rx_data", 32'(rx_data), 32'h3A);

    // Random frames: random divisor, data, gap and occasional bad stop bit.
    for (int n = 0; n < 40; n++) begin
      c   = int'($urandom_range(40, 8));
      b   = 8'($urandom);
      bad = ($urandom_range(7, 0) == 0);
      send_frame(b, c, !bad, -1, -1, 0, 1'b1);
      gap = bad ? c + int'($urandom_range(c, 0)) : int'($urandom_range(2 * c, 0));
      idle(gap);
    end
    expect_drained(200);
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
